cfu_bank_arbiter: RTL and testbench
===================================

Name: cfu_bank_arbiter

Overview:
Shares the four CFU scratchpad memory banks (14-bit address, 32-bit read data, one-cycle read latency) between NUM_REQ independent read requesters, e.g. the CFU command path and a streaming prefetch engine. Arbitration is per bank and round-robin. Requests to different banks are served in the same cycle. Each read returns to its originating requester exactly one cycle after grant.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
NUM_BANKS, 4, number of memory banks (power of two)
ADDR_W, 14, bank word address width
DATA_W, 32, bank read data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester read request
req_ready  out  NUM_REQ  grant; a request is accepted when valid&ready
req_bank  in  NUM_REQ*log2(NUM_BANKS)  target bank per requester
req_addr  in  NUM_REQ*ADDR_W  word address per requester
rsp_valid  out  NUM_REQ  read data valid, one cycle after accept
rsp_data  out  NUM_REQ*DATA_W  read data per requester
bank_addr  out  NUM_BANKS*ADDR_W  address to each bank
bank_ren  out  NUM_BANKS  read enable to each bank
bank_din  in  NUM_BANKS*DATA_W  bank read data, valid the cycle after bank_ren
stall_count  out  32  arbitration-loss counter (optional feature)

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- On reset: all rr pointers = 0, rsp_valid = 0, internal bank-select registers = 0, stall_count = 0. req_ready and bank_ren are combinational and are 0 while no request is valid.
- Per bank b, the candidates are the requesters with req_valid=1 and req_bank=b. The winner is the first candidate at or after ptr[b], wrapping modulo NUM_REQ.
- The grant is combinational in the same cycle: req_ready[winner]=1, bank_ren[b]=1, bank_addr[b]=req_addr[winner]. Losers see req_ready=0 and must hold their request stable.
- On grant, ptr[b] <= winner+1, wrapping to 0 after NUM_REQ-1. ptr[b] is unchanged when bank b has no grant.
- Each requester has at most one request per cycle, so at most NUM_REQ banks are active per cycle.
- When bank b has no winner, bank_addr[b] holds its last driven value and bank_ren[b]=0.
- Response path:
  - On accept, register sel[r] <= req_bank[r] and rsp_valid[r] <= 1.
  - Otherwise rsp_valid[r] <= 0.
  - rsp_data[r] = bank_din[sel[r]], combinational. It is only meaningful while rsp_valid[r]=1.
- Latency is exactly one cycle from accept to rsp_valid. The response path has no backpressure. A requester may issue back-to-back requests and receives back-to-back responses.
- When a requester is granted on consecutive cycles, it gets one response per cycle in order.
- Reset asserted mid-operation drops any in-flight response (rsp_valid=0 next cycle) and returns the pointers to 0.
- An out-of-range req_bank cannot occur because NUM_BANKS is a power of two.

Optional Feature:
CFU_ARB_STATS_EN
- Defined: stall_count increments by the number of requesters with req_valid=1 and req_ready=0 in that cycle. It saturates at 0xFFFFFFFF and clears on reset.
- Undefined: stall_count is tied to 0 and no counter logic is built.

Decomposition:
- Package cfu_arb_pkg holds:
  - BANK_SEL_W = log2(NUM_BANKS);
  - ADDR_W/DATA_W defaults (14/32);
  - typedef bank_sel_t and typedef bank_addr_t.
- Sub-module rr_bank_grant is instantiated once per bank. It takes the candidate vector and returns a one-hot grant plus the registered rr pointer.
- The top level holds the response select registers, the data muxes and the optional counter.

Test Plan:
- Reset, then idle: all req_valid=0 -> bank_ren=0, rsp_valid=0, req_ready=0 for 5 cycles.
- Parallel access, no conflict: req0 (bank 1, addr 0x0010) and req1 (bank 2, addr 0x0020) in the same cycle -> both ready. Next cycle rsp_data0=bank1 model[0x0010] and rsp_data1=bank2 model[0x0020], both rsp_valid=1.
- Conflict with fairness: req0 and req1 both target bank 3 continuously for 4 cycles -> grants alternate r0,r1,r0,r1 and each rsp carries the correct addr's data. With CFU_ARB_STATS_EN, stall_count=4.
- Back-to-back streaming: req0 alone reads bank 0 at addrs 0..7 on consecutive cycles -> 8 consecutive rsp_valid pulses, in order, data = model[0..7].
- Reset mid-stream: assert reset in the cycle after an accept -> rsp_valid=0 next cycle. The first contested grant after reset goes to requester 0.
- Stats off build: same conflict stimulus with the macro undefined -> stall_count stays 0.

Source files
------------

// File: rtl/cfu_arb_pkg.sv
// Shared widths and types for the CFU scratchpad bank arbiter.
package cfu_arb_pkg;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_DATA_W    = 32;

    localparam int BANK_SEL_W = $clog2(DEF_NUM_BANKS);

    typedef logic [BANK_SEL_W-1:0] bank_sel_t;
    typedef logic [DEF_ADDR_W-1:0] bank_addr_t;

endpackage

// File: rtl/rr_bank_grant.sv
// Round-robin grant for a single bank: picks the first candidate at or
// after the stored pointer, and advances the pointer past the winner.
module rr_bank_grant #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] cand_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;
    int unsigned      pos;

    // Scan candidates starting at the pointer (mod NUM_REQ) and compute next pointer.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        win     = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = PTR_W'(pos);
            if (!found && cand_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            grant_o[win] = 1'b1;
            ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // Pointer register; holds when the bank has no grant.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/cfu_bank_arbiter.sv
// Per-bank round-robin arbiter sharing the CFU scratchpad banks between
// NUM_REQ read requesters; responses return one cycle after grant.
// Optional arbitration-loss counter: define CFU_ARB_STATS_EN.
module cfu_bank_arbiter
    import cfu_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*$clog2(NUM_BANKS)-1:0] req_bank,
    input  logic [NUM_REQ*ADDR_W-1:0]            req_addr,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]            rsp_data,
    output logic [NUM_BANKS*ADDR_W-1:0]          bank_addr,
    output logic [NUM_BANKS-1:0]                 bank_ren,
    input  logic [NUM_BANKS*DATA_W-1:0]          bank_din,
    output logic [31:0]                          stall_count
);

    localparam int SEL_W = $clog2(NUM_BANKS);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [SEL_W-1:0]   req_bank_s  [NUM_REQ];
    logic [ADDR_W-1:0]  req_addr_s  [NUM_REQ];
    logic [NUM_REQ-1:0] cand        [NUM_BANKS];
    logic [NUM_REQ-1:0] grant       [NUM_BANKS];
    logic [PTR_W-1:0]   ptr_w       [NUM_BANKS];
    logic [ADDR_W-1:0]  bank_addr_q [NUM_BANKS];
    logic [ADDR_W-1:0]  bank_addr_d [NUM_BANKS];
    logic [SEL_W-1:0]   sel_q       [NUM_REQ];
    logic [SEL_W-1:0]   sel_d       [NUM_REQ];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] accept;

    // Split the flattened request buses and build per-bank candidate vectors.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            req_bank_s[r] = req_bank[r*SEL_W +: SEL_W];
            req_addr_s[r] = req_addr[r*ADDR_W +: ADDR_W];
        end
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            cand[b] = '0;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                cand[b][r] = req_valid[r] && (req_bank_s[r] == SEL_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_bank_grant #(
            .NUM_REQ(NUM_REQ)
        ) u_grant (
            .clk    (clk),
            .reset_i(reset),
            .cand_i (cand[b]),
            .grant_o(grant[b]),
            .ptr_o  (ptr_w[b])
        );

        // Pointer must always name a real requester.
        always_comb begin
            assert (32'(ptr_w[b]) < NUM_REQ);
        end
    end

    // Drive each bank from its winner; an idle bank keeps its last address.
    always_comb begin
        bank_ren  = '0;
        bank_addr = '0;
        req_ready = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_addr_d[b] = bank_addr_q[b];
            bank_ren[b]    = |grant[b];
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (grant[b][r]) begin
                    bank_addr_d[b] = req_addr_s[r];
                end
            end
            bank_addr[b*ADDR_W +: ADDR_W] = bank_addr_d[b];
            req_ready = req_ready | grant[b];
        end
    end

    // Remember the last driven address per bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                bank_addr_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                bank_addr_q[b] <= bank_addr_d[b];
            end
        end
    end

    // Capture the bank each accepted request targeted for the return mux.
    always_comb begin
        accept      = req_valid & req_ready;
        rsp_valid_d = accept;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            sel_d[r] = accept[r] ? req_bank_s[r] : sel_q[r];
        end
    end

    // Response select and valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                sel_q[r] <= '0;
            end
        end else begin
            rsp_valid_q <= rsp_valid_d;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                sel_q[r] <= sel_d[r];
            end
        end
    end

    // Route bank read data back to each requester.
    always_comb begin
        rsp_data = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            rsp_data[r*DATA_W +: DATA_W] = bank_din[32'(sel_q[r])*DATA_W +: DATA_W];
        end
    end

    assign rsp_valid = rsp_valid_q;

`ifdef CFU_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [32:0] stall_sum;
    int unsigned losers;

    // Add this cycle's losing requesters, saturating at all-ones.
    always_comb begin
        losers = 0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (req_valid[r] && !req_ready[r]) begin
                losers = losers + 1;
            end
        end
        stall_sum = {1'b0, stall_q} + 33'(losers);
        stall_d   = stall_sum[32] ? '1 : stall_sum[31:0];
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_cfu_bank_arbiter.sv
// Self-checking bench for cfu_bank_arbiter with a behavioural bank/arbiter model.
module tb_cfu_bank_arbiter;
    import cfu_arb_pkg::*;

    localparam int NR = 2;
    localparam int NB = 4;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SW = 2;
`ifdef CFU_ARB_STATS_EN
    localparam logic [31:0] CONFLICT_STALL = 32'd4;
`else
    localparam logic [31:0] CONFLICT_STALL = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*SW-1:0]  req_bank;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     rsp_valid;
    logic [NR*DW-1:0]  rsp_data;
    logic [NB*AW-1:0]  bank_addr;
    logic [NB-1:0]     bank_ren;
    logic [NB*DW-1:0]  bank_din = '0;
    logic [31:0]       stall_count;

    int total = 0;
    int bad   = 0;

    // Stimulus variables
    logic [NR-1:0] v;
    bank_sel_t     bk [NR];
    bank_addr_t    ad [NR];

    // Reference model state
    int            ptr_m [NB];
    int            win_m [NB];
    logic [NR-1:0] exp_ready;
    logic [NB-1:0] exp_ren;
    bank_addr_t    exp_baddr [NB];
    logic [NR-1:0] exp_rv;
    logic [31:0]   exp_rd [NR];
    longint        stall_m;
    logic [31:0]   exp_stall;

    always #5 clk = ~clk;

    cfu_bank_arbiter #(
        .NUM_REQ  (NR),
        .NUM_BANKS(NB),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_bank   (req_bank),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .bank_addr  (bank_addr),
        .bank_ren   (bank_ren),
        .bank_din   (bank_din),
        .stall_count(stall_count)
    );

    function automatic logic [31:0] mem(input int b, input int a);
        return (32'(b) * 32'h0100_0001) ^ (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Bank memories: one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_ren[b]) begin
                bank_din[b*DW +: DW] <= mem(b, int'(bank_addr[b*AW +: AW]));
            end
        end
    end

    task automatic apply();
        req_valid = v;
        for (int r = 0; r < NR; r++) begin
            req_bank[r*SW +: SW] = bk[r];
            req_addr[r*AW +: AW] = ad[r];
        end
    endtask

    // Expected grants from the round-robin rule for the current inputs.
    task automatic model_eval();
        exp_ready = '0;
        exp_ren   = '0;
        for (int b = 0; b < NB; b++) begin
            win_m[b] = -1;
            for (int k = 0; k < NR; k++) begin
                int r;
                r = (ptr_m[b] + k) % NR;
                if (win_m[b] < 0 && v[r] && int'(bk[r]) == b) win_m[b] = r;
            end
            if (win_m[b] >= 0) begin
                exp_ren[b]          = 1'b1;
                exp_ready[win_m[b]] = 1'b1;
                exp_baddr[b]        = ad[win_m[b]];
            end
        end
    endtask

    task automatic commit();
        if (reset) begin
            for (int b = 0; b < NB; b++) ptr_m[b] = 0;
            exp_rv  = '0;
            stall_m = 0;
        end else begin
            for (int b = 0; b < NB; b++)
                if (win_m[b] >= 0) ptr_m[b] = (win_m[b] + 1) % NR;
            for (int r = 0; r < NR; r++) begin
                exp_rv[r] = exp_ready[r];
                if (exp_ready[r]) exp_rd[r] = mem(int'(bk[r]), int'(ad[r]));
                if (v[r] && !exp_ready[r]) stall_m++;
            end
            if (stall_m > 64'hFFFF_FFFF) stall_m = 64'hFFFF_FFFF;
        end
`ifdef CFU_ARB_STATS_EN
        exp_stall = stall_m[31:0];
`else
        exp_stall = '0;
`endif
    endtask

    task automatic cycle();
        apply();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v = '0;
        cycle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v = '0;
        for (int r = 0; r < NR; r++) begin bk[r] = '0; ad[r] = '0; end
        for (int i = 0; i < 2; i++) begin cycle(); tick(); end
        total++;
        if (rsp_valid !== '0 || stall_count !== '0) begin
            bad++;
            $display("FAIL reset_state rsp_valid=%b stall=%0d required 0/0", rsp_valid, stall_count);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (req_ready !== '0 || bank_ren !== '0 || rsp_valid !== '0) begin
                bad++;
                $display("FAIL idle cyc=%0d ready=%b ren=%b rsp_valid=%b required all 0", i, req_ready, bank_ren, rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_parallel();
        v = 2'b11;
        bk[0] = 2'd1; ad[0] = 14'h0010;
        bk[1] = 2'd2; ad[1] = 14'h0020;
        cycle();
        total++;
        if (req_ready !== 2'b11 || bank_ren !== 4'b0110) begin
            bad++;
            $display("FAIL par_grant ready=%b ren=%b required 11/0110", req_ready, bank_ren);
        end
        total++;
        if (bank_addr[1*AW +: AW] !== 14'h0010 || bank_addr[2*AW +: AW] !== 14'h0020) begin
            bad++;
            $display("FAIL par_addr b1=%h b2=%h required 0010/0020", bank_addr[1*AW +: AW], bank_addr[2*AW +: AW]);
        end
        tick();
        v = '0;
        cycle();
        total++;
        if (rsp_valid !== 2'b11 || rsp_data[0 +: DW] !== mem(1, 'h10) || rsp_data[DW +: DW] !== mem(2, 'h20)) begin
            bad++;
            $display("FAIL par_rsp valid=%b d0=%h d1=%h required 11/%h/%h", rsp_valid, rsp_data[0 +: DW], rsp_data[DW +: DW], mem(1, 'h10), mem(2, 'h20));
        end
        tick();
    endtask

    task automatic test_conflict();
        int prev;
        do_reset();
        prev = -1;
        v = 2'b11;
        bk[0] = 2'd3; ad[0] = 14'h0100;
        bk[1] = 2'd3; ad[1] = 14'h0200;
        for (int c = 0; c < 4; c++) begin
            int w;
            w = c % 2;
            cycle();
            total++;
            if (req_ready !== NR'(1 << w) || bank_ren !== 4'b1000 || bank_addr[3*AW +: AW] !== ad[w]) begin
                bad++;
                $display("FAIL conflict_grant c=%0d ready=%b ren=%b addr=%h required %b/1000/%h", c, req_ready, bank_ren, bank_addr[3*AW +: AW], NR'(1 << w), ad[w]);
            end
            if (prev >= 0) begin
                total++;
                if (rsp_valid !== NR'(1 << prev) || rsp_data[prev*DW +: DW] !== mem(3, int'(ad[prev]))) begin
                    bad++;
                    $display("FAIL conflict_rsp c=%0d valid=%b data=%h required %b/%h", c, rsp_valid, rsp_data[prev*DW +: DW], NR'(1 << prev), mem(3, int'(ad[prev])));
                end
            end
            prev = w;
            tick();
        end
        v = '0;
        cycle();
        total++;
        if (rsp_valid !== 2'b10 || rsp_data[DW +: DW] !== mem(3, 'h200)) begin
            bad++;
            $display("FAIL conflict_last valid=%b data=%h required 10/%h", rsp_valid, rsp_data[DW +: DW], mem(3, 'h200));
        end
        total++;
        if (stall_count !== CONFLICT_STALL) begin
            bad++;
            $display("FAIL conflict_stall got=%0d required=%0d", stall_count, CONFLICT_STALL);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        v = 2'b01;
        bk[0] = 2'd0;
        for (int i = 0; i <= 8; i++) begin
            if (i == 8) v = '0;
            ad[0] = bank_addr_t'(i);
            cycle();
            if (i < 8) begin
                total++;
                if (req_ready !== 2'b01) begin
                    bad++;
                    $display("FAIL b2b_ready i=%0d got=%b required 01", i, req_ready);
                end
            end
            if (i > 0) begin
                total++;
                if (rsp_valid !== 2'b01 || rsp_data[0 +: DW] !== mem(0, i - 1)) begin
                    bad++;
                    $display("FAIL b2b_rsp i=%0d valid=%b data=%h required 01/%h", i, rsp_valid, rsp_data[0 +: DW], mem(0, i - 1));
                end
            end
            tick();
        end
        cycle();
        total++;
        if (rsp_valid !== '0) begin
            bad++;
            $display("FAIL b2b_end valid=%b required 00", rsp_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        v = 2'b01;
        bk[0] = 2'd2; ad[0] = 14'h0033;
        cycle();
        tick();
        reset = 1'b1;
        cycle();
        total++;
        if (rsp_valid !== 2'b01) begin
            bad++;
            $display("FAIL rmid_pre valid=%b required 01", rsp_valid);
        end
        tick();
        reset = 1'b0;
        v = '0;
        cycle();
        total++;
        if (rsp_valid !== '0 || stall_count !== '0) begin
            bad++;
            $display("FAIL rmid_drop valid=%b stall=%0d required 00/0", rsp_valid, stall_count);
        end
        tick();
        v = 2'b11;
        bk[0] = 2'd2; ad[0] = 14'h0040;
        bk[1] = 2'd2; ad[1] = 14'h0041;
        cycle();
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL rmid_first ready=%b required 01", req_ready);
        end
        tick();
        v = '0;
        cycle();
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] held;
        held = '0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int r = 0; r < NR; r++) begin
                if (!held[r]) begin
                    v[r]  = ($urandom_range(0, 3) != 0);
                    bk[r] = bank_sel_t'($urandom_range(0, NB - 1));
                    ad[r] = bank_addr_t'($urandom);
                end
            end
            cycle();
            total++;
            if (req_ready !== exp_ready || bank_ren !== exp_ren) begin
                bad++;
                $display("FAIL rnd_grant c=%0d ready=%b ren=%b required %b/%b", c, req_ready, bank_ren, exp_ready, exp_ren);
            end
            for (int b = 0; b < NB; b++) begin
                if (exp_ren[b]) begin
                    total++;
                    if (bank_addr[b*AW +: AW] !== exp_baddr[b]) begin
                        bad++;
                        $display("FAIL rnd_addr c=%0d bank=%0d got=%h required=%h", c, b, bank_addr[b*AW +: AW], exp_baddr[b]);
                    end
                end
            end
            total++;
            if (rsp_valid !== exp_rv) begin
                bad++;
                $display("FAIL rnd_rsp_valid c=%0d got=%b required=%b", c, rsp_valid, exp_rv);
            end
            for (int r = 0; r < NR; r++) begin
                if (exp_rv[r]) begin
                    total++;
                    if (rsp_data[r*DW +: DW] !== exp_rd[r]) begin
                        bad++;
                        $display("FAIL rnd_rsp_data c=%0d req=%0d got=%h required=%h", c, r, rsp_data[r*DW +: DW], exp_rd[r]);
                    end
                end
            end
            total++;
            if (stall_count !== exp_stall) begin
                bad++;
                $display("FAIL rnd_stall c=%0d got=%0d required=%0d", c, stall_count, exp_stall);
            end
            held = reset ? '0 : (v & ~exp_ready);
            tick();
        end
        reset = 1'b0;
        v = '0;
        cycle();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_bank  = '0;
        req_addr  = '0;
        v         = '0;
        exp_rv    = '0;
        stall_m   = 0;
        exp_stall = '0;
        for (int b = 0; b < NB; b++) begin ptr_m[b] = 0; win_m[b] = -1; exp_baddr[b] = '0; end
        for (int r = 0; r < NR; r++) exp_rd[r] = '0;

        test_reset();
        test_parallel();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
